// File: rtl/pipe_dmem_ctrl_pkg.sv
// Shared Y86 constants for the data-memory stage: status codes, memory icodes, FSM states.
// Also holds the icode-to-access classification helpers.
package pipe_dmem_ctrl_pkg;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic is_write(input logic [3:0] icode);
      return (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
   endfunction

   function automatic logic is_read(input logic [3:0] icode);
      return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
   endfunction

endpackage

// File: rtl/pipe_dmem_ctrl_if.sv
// Request/response bundle between the E/M register, the memory stage and the M/W register.
// master = pipeline side issuing requests, slave = the memory stage.
interface pipe_dmem_ctrl_if #(
   parameter int DATA_W = 64
);
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        M_icode;
   logic [DATA_W-1:0] M_valE;
   logic [DATA_W-1:0] M_valA;
   logic [DATA_W-1:0] M_valP;
   logic [2:0]        M_stat;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] m_valM;
   logic [2:0]        m_stat;

   modport master (
      output req_valid, M_icode, M_valE, M_valA, M_valP, M_stat, rsp_ready,
      input  req_ready, rsp_valid, m_valM, m_stat
   );

   modport slave (
      input  req_valid, M_icode, M_valE, M_valA, M_valP, M_stat, rsp_ready,
      output req_ready, rsp_valid, m_valM, m_stat
   );
endinterface

// File: rtl/pipe_dmem_ctrl_dmem_array.sv
// Single-port synchronous word RAM; read data is registered and only updates on an enabled cycle.
// Contents have no reset.
module pipe_dmem_ctrl_dmem_array #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 8192,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end
         rdata_o <= mem_q[addr_i];
      end
   end

endmodule

// File: rtl/pipe_dmem_ctrl.sv
// Y86 data-memory stage: decodes M_icode into a RAM access, range-checks the address,
// and paces each transaction through IDLE -> WAIT -> RESP with a valid/ready handshake.
module pipe_dmem_ctrl
   import pipe_dmem_ctrl_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int DEPTH      = 8192,
   parameter int ADDR_LIMIT = 258,
   parameter int WAIT_CYC   = 0
) (
   input logic               clk,
   input logic               rst_n,
   pipe_dmem_ctrl_if.slave   bus
);

   localparam int                AW      = $clog2(DEPTH);
   localparam logic [DATA_W-1:0] LIMIT_W = DATA_W'(ADDR_LIMIT);
   localparam logic [3:0]        WAIT_4  = 4'(WAIT_CYC);

   state_e            state_q;
   logic [3:0]        wcnt_q;
   logic              we_q, re_q, rd_q, rsp_valid_q;
   logic [2:0]        acc_stat_q, m_stat_q;
   logic [AW-1:0]     idx_q;
   logic [DATA_W-1:0] wdata_q;

   logic              we_d, re_d;
   logic [2:0]        stat_d;
   logic [DATA_W-1:0] addr_d, wdata_d;
   logic [AW-1:0]     idx_d;
   logic              req_ready, accept, commit;
   logic [DATA_W-1:0] rdata;

   // Decode of the request as presented; only takes effect on accept.
   always_comb begin
      we_d    = 1'b0;
      re_d    = 1'b0;
      stat_d  = SAOK;
      addr_d  = ((bus.M_icode == IRET) || (bus.M_icode == IPOPQ)) ? bus.M_valA : bus.M_valE;
      wdata_d = (bus.M_icode == ICALL) ? bus.M_valP : bus.M_valA;
      if (bus.M_stat != SAOK) begin
         stat_d = bus.M_stat;
      end else if ((is_write(bus.M_icode) || is_read(bus.M_icode)) && (addr_d >= LIMIT_W)) begin
         stat_d = SADR;
      end else begin
         we_d = is_write(bus.M_icode);
         re_d = is_read(bus.M_icode);
      end
   end

   assign idx_d     = addr_d[AW-1:0];
   assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready);
   assign accept    = bus.req_valid && req_ready;
   assign commit    = (state_q == ST_WAIT) && (wcnt_q == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wcnt_q      <= 4'd0;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         acc_stat_q  <= SAOK;
         rsp_valid_q <= 1'b0;
         rd_q        <= 1'b0;
         m_stat_q    <= SAOK;
      end else begin
         if (accept) begin
            we_q       <= we_d;
            re_q       <= re_d;
            acc_stat_q <= stat_d;
            wcnt_q     <= WAIT_4;
         end
         unique case (state_q)
            ST_IDLE: begin
               if (accept) state_q <= ST_WAIT;
            end
            // The RAM access happens on the edge that leaves WAIT, so reset before it drops the write.
            ST_WAIT: begin
               if (wcnt_q == 4'd0) begin
                  state_q     <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rd_q        <= re_q;
                  m_stat_q    <= acc_stat_q;
               end else begin
                  wcnt_q <= wcnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= accept ? ST_WAIT : ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
      end
   end

   pipe_dmem_ctrl_dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk     (clk),
      .en_i    (commit),
      .we_i    (we_q),
      .addr_i  (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (rdata)
   );

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.m_stat    = m_stat_q;
   assign bus.m_valM    = (rsp_valid_q && rd_q) ? rdata : '0;

endmodule
